// File: rtl/ndata_width_downsizer_pkg.sv
// Shared stream helpers: slot sizing and per-slot keep inspection for the
// ndata width converters.
package ndata_width_downsizer_pkg;

  // Widest keep vector the slot helpers accept.
  localparam int MAX_KEEP = 1024;

  // Output beats produced from one full input beat.
  function automatic int num_slots(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Slot counter width; at least one bit so the counter is always declarable.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width checks.
  function automatic logic is_pow2(input int w);
    return (w > 0) && ((w & (w - 1)) == 0);
  endfunction

  // True when any keep bit inside slot 'slot' (of 'width' elements) is set.
  function automatic logic slot_has_keep(input logic [MAX_KEEP-1:0] keep,
                                         input int slot, input int width);
    logic [MAX_KEEP-1:0] shifted;
    logic [MAX_KEEP-1:0] mask;
    shifted = keep >> (slot * width);
    mask    = (MAX_KEEP'(1) << width) - MAX_KEEP'(1);
    return |(shifted & mask);
  endfunction

endpackage

// File: rtl/ndata_i.sv
// Element stream interface: data, per-element keep, last, valid/ready.
interface ndata_i #(
  parameter type data_t       = logic [31:0],
  parameter int  NUM_ELEMENTS = 1
);
  data_t [NUM_ELEMENTS-1:0] data;
  logic  [NUM_ELEMENTS-1:0] keep;
  logic                     last;
  logic                     valid;
  logic                     ready;

  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/ndata_last_slot_finder.sv
// Combinational search for the highest slot of a wide keep vector that holds
// at least one kept element; 0 when the whole vector is empty.
module ndata_last_slot_finder
  import ndata_width_downsizer_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2,
  localparam int NUM_SLOTS = IN_WIDTH / OUT_WIDTH,
  localparam int SLOT_W    = slot_w(NUM_SLOTS)
) (
  input  logic [IN_WIDTH-1:0] keep,
  output logic [SLOT_W-1:0]   last_slot
);

  // Per-slot keep OR, later slots override earlier ones (highest-set wins).
  always_comb begin
    last_slot = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (slot_has_keep(MAX_KEEP'(keep), s, OUT_WIDTH)) last_slot = SLOT_W'(s);
    end
  end

endmodule

// File: rtl/ndata_width_downsizer.sv
// Splits each wide input beat into up to IN_WIDTH/OUT_WIDTH narrow beats,
// lowest slot first, skipping trailing empty slots and re-asserting last on
// the final emitted slot.
module ndata_width_downsizer
  import ndata_width_downsizer_pkg::*;
#(
  parameter type data_t = logic [31:0]
) (
  input logic clk,
  input logic rst_n,
  ndata_i.s   in,
  ndata_i.m   out
);

  localparam int IN_WIDTH  = in.NUM_ELEMENTS;
  localparam int OUT_WIDTH = out.NUM_ELEMENTS;
  localparam int NUM_SLOTS = num_slots(IN_WIDTH, OUT_WIDTH);
  localparam int SLOT_W    = slot_w(NUM_SLOTS);
  localparam int EW        = $bits(data_t);

  if (!((IN_WIDTH >= OUT_WIDTH) && is_pow2(IN_WIDTH) && is_pow2(OUT_WIDTH) &&
        ((IN_WIDTH % OUT_WIDTH) == 0))) begin : g_bad_widths
    $error("ndata_width_downsizer: illegal IN_WIDTH/OUT_WIDTH combination");
  end

  if (IN_WIDTH == OUT_WIDTH) begin : g_passthrough
    // Equal widths: nothing to split, so wire straight through without state.
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n};
    assign out.data  = in.data;
    assign out.keep  = in.keep;
    assign out.last  = in.last;
    assign out.valid = in.valid;
    assign in.ready  = out.ready;
  end else begin : g_split
    logic [NUM_SLOTS-1:0][OUT_WIDTH*EW-1:0] buf_data;
    logic [NUM_SLOTS-1:0][OUT_WIDTH-1:0]    buf_keep;
    logic                                   buf_last;
    logic                                   buf_valid;
    logic [SLOT_W-1:0]                      slot;
    logic [SLOT_W-1:0]                      last_slot;
    logic                                   at_last;
    logic                                   in_ready;
    logic                                   load;
    logic                                   out_hs;

    ndata_last_slot_finder #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_last_slot (
      .keep     (buf_keep),
      .last_slot(last_slot)
    );

    assign at_last  = (slot == last_slot);
    // A new beat may enter while the final slot is leaving, so full-rate
    // input beats keep the narrow side busy every cycle.
    assign in_ready = !buf_valid || (out.ready && at_last);
    // Beats with no kept element and no last carry nothing and are dropped.
    assign load     = in.valid && in_ready && ((|in.keep) || in.last);
    assign out_hs   = buf_valid && out.ready;

    assign in.ready  = in_ready;
    assign out.data  = buf_data[slot];
    assign out.keep  = buf_keep[slot];
    assign out.last  = buf_last && at_last;
    assign out.valid = buf_valid;

    // Buffer occupancy and slot walk; a load always restarts at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_valid <= 1'b0;
        slot      <= '0;
      end else if (load) begin
        buf_valid <= 1'b1;
        slot      <= '0;
      end else if (out_hs) begin
        if (!at_last) begin
          slot <= slot + SLOT_W'(1);
        end else begin
          slot      <= '0;
          buf_valid <= 1'b0;
        end
      end
    end

    // Wide beat capture; contents are meaningless while buf_valid is low.
    always_ff @(posedge clk) begin
      if (load) begin
        buf_data <= in.data;
        buf_keep <= in.keep;
        buf_last <= in.last;
      end
    end
  end

endmodule
